// File: rtl/sync_fifo_pkg.sv
// fifo_pkg: default FIFO geometry and the address-width helper shared by RTL and bench.
package fifo_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int DEPTH_DEF      = 16;
   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write/read handshake, status flags and error pulses of the FIFO.
interface sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
);
   localparam int CW = addr_w(DEPTH) + 1;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;
   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH register array, sync write port and registered read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   localparam int AW        = addr_w(DEPTH)
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_we,
   input  logic [AW-1:0]         i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [AW-1:0]         i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   // Storage is never reset; only the output register is.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)    o_rdata <= '0;
      else if (i_re) o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, occupancy flags and over/underflow pulses.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2
)(
   input logic        clk,
   input logic        rst_n,
   sync_fifo_if.slave bus
);
   localparam int AW                = addr_w(DEPTH);
   localparam logic [AW:0] AF_CNT   = AF_LEVEL[AW:0];
   localparam logic [AW:0] AE_CNT   = AE_LEVEL[AW:0];
   logic [AW:0] r_wr_ptr, r_rd_ptr, w_count;
   logic        r_overflow, r_underflow;
   logic        w_full, w_empty, w_wr_ok, w_rd_ok;
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = r_wr_ptr == r_rd_ptr;
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_wr_ok = bus.wr_en && !w_full;
   assign w_rd_ok = bus.rd_en && !w_empty;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_overflow  <= bus.wr_en && w_full;
         r_underflow <= bus.rd_en && w_empty;
      end
   fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_wr_ok),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (bus.wr_data),
      .i_re    (w_rd_ok),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (bus.rd_data)
   );
   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.almost_full  = w_count >= AF_CNT;
   assign bus.almost_empty = w_count <= AE_CNT;
   assign bus.count        = w_count;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous single-clock FIFO, the design-under-test driven by the team's SystemVerilog FIFO testbench (env/agent/driver/monitor) through the shared interface. It buffers `wr_data` words on write requests and returns them in order on read requests. It reports `full`, `empty`, programmable almost-flags, occupancy and sticky-free error pulses for over/underflow. The read port is registered.

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `DEPTH`, 16: number of entries; power of two, ≥ 4.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ AE_LEVEL.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request.
- `wr_data`  in  DATA_WIDTH  write word, sampled with `wr_en`.
- `rd_en`  in  1  read request.
- `rd_data`  out  DATA_WIDTH  read word, registered.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `almost_empty`  out  1  count ≤ AE_LEVEL.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse: write rejected.
- `underflow`  out  1  one-cycle pulse: read rejected.

## Operation
- Pointers `wr_ptr`, `rd_ptr` are $clog2(DEPTH)+1 bits: low bits address memory, MSB is wrap bit; both wrap naturally modulo 2·DEPTH.
- `count` = `wr_ptr - rd_ptr` (unsigned, ADDR_W+1 bits). `empty` = pointers equal; `full` = addresses equal, wrap bits differ.
- Write accepted iff `wr_en && !full` (full sampled before the edge). Accepted: mem[wr_ptr] ← `wr_data`, `wr_ptr`+1.
- Read accepted iff `rd_en && !empty`. Accepted: `rd_data` ← mem[rd_ptr], `rd_ptr`+1.
- Simultaneous read and write, neither full nor empty: both accepted, count unchanged.
- Full with `wr_en && rd_en`: read accepted, write rejected, `overflow` pulses. No write-through.
- Empty with `wr_en && rd_en`: write accepted, read rejected, `underflow` pulses. No fall-through; written word readable next cycle.
- Rejected write: memory and `wr_ptr` unchanged. Rejected read: `rd_data` and `rd_ptr` unchanged.
- `rd_data` holds its last value when no read is accepted.
- No state machine beyond the pointer pair; all flags are pure functions of registered pointers except `overflow`/`underflow` (registered).

## Timing
- Read latency 1 cycle: word appears on `rd_data` after the edge that accepts `rd_en`.
- Flags and `count` change after the accepting edge (same edge as pointer update); no combinational path from `wr_en`/`rd_en` to any output.
- `overflow`/`underflow` assert for exactly the cycle after the rejecting edge; back-to-back rejections give a continuous high.
- Reset (asynchronous assert, synchronous release by system): pointers 0, `rd_data` 0, `count` 0, `empty` 1, `almost_empty` 1, `full` 0, `almost_full` 0, `overflow` 0, `underflow` 0. Memory contents not reset and never observable before being written.
- Reset mid-traffic discards all stored words; first read after release is rejected until a write occurs.

## Structure
- Package `fifo_pkg`: default `DATA_WIDTH`/`DEPTH` constants and the `ADDR_W = $clog2(DEPTH)` helper function, shared with the testbench transaction class and scoreboard.
- Sub-module `fifo_mem`: DEPTH×DATA_WIDTH register array, one synchronous write port, one synchronous registered read port with read-enable. Top level owns pointers, flags, error pulses.

## Test plan
- Reset then idle: `empty`=1, `almost_empty`=1, `full`=0, `count`=0, `rd_data`=0 for 10 cycles.
- Write 0x01..0x10 (16 words, DEPTH=16), then read 16: `full`=1 after 16th write, `almost_full` from count 14; reads return 0x01..0x10 in order, each 1 cycle after `rd_en`; `empty`=1 at end.
- Full, then `wr_en`=1 with 0xAA for 1 cycle: `overflow` pulses once, `count` stays 16, 0xAA never read back.
- Empty, `rd_en`=1 with `wr_en`=1 data 0x55: `underflow` pulses, `count`=1, next-cycle read returns 0x55.
- Fill to 8, then 40 cycles of simultaneous read/write with incrementing data: `count` stays 8, order preserved across pointer wrap (≥2 full laps).
- Fill to 5, assert `rst_n`=0 mid-write: all outputs at reset values immediately; after release, read rejected with `underflow`.
